// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, FSM states and defaults for the UART debug command engine.
package uart_cmd_pkg;

    typedef enum logic [7:0] {
        CMD_WRITE = 8'h02,
        CMD_READ  = 8'h03,
        CMD_HOLD  = 8'h06,
        CMD_RUN   = 8'h07
    } cmd_op_t;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA,
        WR_EXEC,
        RD_ISSUE,
        RD_WAIT,
        TX_SEND,
        TX_WAIT
    } cmd_state_t;

    localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

endpackage

// File: rtl/rd_lat_counter.sv
// Loadable down-counter; `last` flags the final counted cycle (count == 1).
module rd_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/uart_cmd_engine.sv
// Host debug UART command responder: parses WRITE/READ/HOLD/RUN and drives the system bus.
// Optional inter-byte timeout is compiled in with UART_CMD_TIMEOUT_EN.
module uart_cmd_engine
    import uart_cmd_pkg::*;
#(
    parameter int         RD_LAT   = 2,
    parameter logic [7:0] ERR_BYTE = DEFAULT_ERR_BYTE
`ifdef UART_CMD_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 2500000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        overrun
);

    cmd_state_t state, next_state;
    logic       is_read;
    logic       lat_last;
    logic       drop;
    logic       timed_out;

    rd_lat_counter #(.W(4)) u_rd_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (state == RD_ISSUE),
        .en       (state == RD_WAIT),
        .load_val (4'(RD_LAT)),
        .last     (lat_last)
    );

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic in_rx_phase;
    logic to_last;

    assign in_rx_phase = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);

    // Reloading on every received byte also arms the counter on the opcode byte.
    rd_lat_counter #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (rx_valid),
        .en       (in_rx_phase),
        .load_val (TO_W'(TIMEOUT_CYCLES)),
        .last     (to_last)
    );

    assign timed_out = in_rx_phase && !rx_valid && to_last;
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        tx_start   = 1'b0;
        drop       = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    next_state = ADDR_HI;
                end
            end
            ADDR_HI: begin
                if (rx_valid)       next_state = ADDR_LO;
                else if (timed_out) next_state = IDLE;
            end
            ADDR_LO: begin
                if (rx_valid)       next_state = is_read ? RD_ISSUE : DATA;
                else if (timed_out) next_state = IDLE;
            end
            DATA: begin
                if (rx_valid)       next_state = WR_EXEC;
                else if (timed_out) next_state = IDLE;
            end
            WR_EXEC: begin
                drop       = rx_valid;
                mem_we     = cpu_hold;
                next_state = IDLE;
            end
            RD_ISSUE: begin
                drop       = rx_valid;
                mem_re     = cpu_hold;
                next_state = cpu_hold ? RD_WAIT : TX_SEND;
            end
            RD_WAIT: begin
                drop = rx_valid;
                if (lat_last) next_state = TX_SEND;
            end
            TX_SEND: begin
                drop = rx_valid;
                if (!tx_active) begin
                    tx_start   = 1'b1;
                    next_state = TX_WAIT;
                end
            end
            TX_WAIT: begin
                drop = rx_valid;
                if (tx_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_read   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_data   <= '0;
            cpu_hold  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_valid) begin
                unique case (state)
                    IDLE: begin
                        is_read <= (rx_data == CMD_READ);
                        if (rx_data == CMD_HOLD) cpu_hold <= 1'b1;
                        if (rx_data == CMD_RUN)  cpu_hold <= 1'b0;
                    end
                    ADDR_HI: mem_addr[15:8] <= rx_data;
                    ADDR_LO: mem_addr[7:0]  <= rx_data;
                    DATA:    mem_wdata      <= rx_data;
                    default: ;
                endcase
            end
            if (state == RD_ISSUE && !cpu_hold) tx_data <= ERR_BYTE;
            if (state == RD_WAIT && lat_last)   tx_data <= mem_rdata;
            if (drop || timed_out)              overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Self-checking bench for uart_cmd_engine: directed protocol scenarios plus random command streams.
`timescale 1ns/1ps
module tb_uart_cmd_engine;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        cpu_hold;
    logic        busy;
    logic        overrun;

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_engine #(.RD_LAT(RD_LAT), .TIMEOUT_CYCLES(100)) dut (
`else
    uart_cmd_engine #(.RD_LAT(RD_LAT)) dut (
`endif
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy), .overrun(overrun));

    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; logic [7:0] data; int cyc; } ev_t;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   last_rx_cyc = -1;
    int   rd_pend_cyc = -100;
    logic [15:0] rd_pend_addr = 16'h0;
    int   n_starts = 0;
    int   n_served = 0;
    int   tx_cnt = 0;
    int   both_strobes = 0;
    int   unstable = 0;
    int   start_busy = 0;
    logic [7:0] tx_ref = 8'h00;
    ev_t  wr_q[$];
    ev_t  rd_q[$];
    ev_t  tx_q[$];
    logic [7:0] bus_mem [int];

    // Reference model state.
    logic       ref_hold = 1'b0;
    logic       ref_ovr = 1'b0;
    logic [7:0] ref_mem [int];

    // Power-on memory contents; address 16'h0123 holds 8'h3C.
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h1E;
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bus/UART monitor and memory read-data model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] cur;
        if (rx_valid) last_rx_cyc = cyc;
        if (mem_we && mem_re) both_strobes++;
        if (mem_we) begin
            wr_q.push_back('{mem_addr, mem_wdata, cyc});
            bus_mem[int'(mem_addr)] = mem_wdata;
        end
        if (mem_re) begin
            rd_q.push_back('{mem_addr, 8'h00, cyc});
            rd_pend_cyc  = cyc;
            rd_pend_addr = mem_addr;
        end
        if (tx_start) begin
            if (tx_active) start_busy++;
            tx_q.push_back('{16'h0, tx_data, cyc});
            tx_ref = tx_data;
            n_starts++;
        end else if (tx_active && tx_data !== tx_ref) begin
            unstable++;
        end
        cur = bus_mem.exists(int'(rd_pend_addr)) ? bus_mem[int'(rd_pend_addr)] : init_val(rd_pend_addr);
        mem_rdata = (cyc == rd_pend_cyc + RD_LAT) ? cur : ~cur;
    end

    // UART transmitter model: busy for a random number of cycles per byte.
    always @(posedge clk) begin
        #1;
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done   = 1'b1;
                tx_active = 1'b0;
            end
        end else if (n_starts > n_served) begin
            n_served++;
            tx_active = 1'b1;
            tx_cnt    = $urandom_range(4, 10);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        repeat ($urandom_range(0, max_gap)) @(posedge clk);
        @(posedge clk) #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk) #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || tx_active) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < 400), 1);
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] data);
        int wb = wr_q.size();
        int rb = rd_q.size();
        int tb = tx_q.size();
        logic [7:0] exp_tx;
        send_byte(op, 3);
        if (op == 8'h02 || op == 8'h03) begin
            send_byte(addr[15:8], 3);
            send_byte(addr[7:0], 3);
        end
        if (op == 8'h02) send_byte(data, 3);
        wait_idle();
        if (op == 8'h06) ref_hold = 1'b1;
        if (op == 8'h07) ref_hold = 1'b0;
        check("wr_count", wr_q.size() - wb, (op == 8'h02 && ref_hold) ? 1 : 0);
        check("rd_count", rd_q.size() - rb, (op == 8'h03 && ref_hold) ? 1 : 0);
        check("tx_count", tx_q.size() - tb, (op == 8'h03) ? 1 : 0);
        if (op == 8'h02 && ref_hold && wr_q.size() == wb + 1) begin
            check("wr_addr", wr_q[wb].addr, addr);
            check("wr_data", wr_q[wb].data, data);
            check("wr_lat", wr_q[wb].cyc - last_rx_cyc, 1);
            ref_mem[int'(addr)] = data;
        end
        if (op == 8'h03 && tx_q.size() == tb + 1) begin
            exp_tx = ref_hold ? ref_read(addr) : 8'hEE;
            check("tx_byte", tx_q[tb].data, exp_tx);
            if (ref_hold && rd_q.size() == rb + 1) begin
                check("rd_addr", rd_q[rb].addr, addr);
                check("rd_lat", rd_q[rb].cyc - last_rx_cyc, 1);
                check("tx_lat", tx_q[tb].cyc - rd_q[rb].cyc, RD_LAT + 1);
            end
        end
        check("cpu_hold", cpu_hold, ref_hold);
        check("overrun", overrun, ref_ovr);
        check("busy_end", busy, 0);
    endtask

    initial begin
        int tb0;
        int n;
        logic [7:0] b;
        logic [15:0] pool [4] = '{16'h8000, 16'h0123, 16'hFFFF, 16'h0010};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_txs", tx_start, 0);
        check("rst_ovr", overrun, 0);
        check("rst_addr", mem_addr, 0);
        @(negedge clk) rst = 1'b1;

        // Access while running: no strobes, error byte returned
        run_cmd(8'h02, 16'h0010, 8'h55);
        run_cmd(8'h03, 16'h0010, 8'h00);

        // Unknown opcode ignored, stray byte during response sets overrun
        run_cmd(8'h09, 16'h0000, 8'h00);
        tb0 = tx_q.size();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n = 0;
        while (tx_q.size() == tb0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ovr_tx_seen", 32'(n < 100), 1);
        send_byte(8'h77, 0);
        wait_idle();
        ref_ovr = 1'b1;
        check("ovr_tx_count", tx_q.size() - tb0, 1);
        if (tx_q.size() == tb0 + 1) check("ovr_tx_byte", tx_q[tb0].data, 8'hEE);
        check("ovr_flag", overrun, 1);
        check("ovr_busy", busy, 0);

        // Asynchronous reset mid-command
        send_byte(8'h06, 0);
        send_byte(8'h02, 0);
        send_byte(8'h80, 0);
        check("mid_busy", busy, 1);
        check("mid_hold", cpu_hold, 1);
        #3 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hold", cpu_hold, 0);
        check("arst_we", mem_we, 0);
        check("arst_ovr", overrun, 0);
        @(negedge clk) rst = 1'b1;
        ref_hold = 1'b0;
        ref_ovr  = 1'b0;
        run_cmd(8'h06, 16'h0000, 8'h00);
        run_cmd(8'h02, 16'h8001, 8'h7E);

        // Write and read while held
        run_cmd(8'h02, 16'h8000, 8'hA5);
        run_cmd(8'h03, 16'h0123, 8'h00);
        run_cmd(8'h03, 16'h8000, 8'h00);

        // Random command stream
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 9);
            logic [15:0] a = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : 16'($urandom);
            logic [7:0]  d = 8'($urandom);
            case (r)
                0, 1, 2: run_cmd(8'h02, a, d);
                3, 4, 5: run_cmd(8'h03, a, d);
                6, 9:    run_cmd(8'h06, a, d);
                7:       run_cmd(8'h07, a, d);
                default: begin
                    do b = 8'($urandom_range(0, 255)); while (b inside {8'h02, 8'h03, 8'h06, 8'h07});
                    run_cmd(b, a, d);
                end
            endcase
        end

`ifdef UART_CMD_TIMEOUT_EN
        // Partial command abandoned after the inter-byte timeout
        tb0 = wr_q.size();
        check("to_ovr_before", overrun, 0);
        send_byte(8'h02, 0);
        send_byte(8'h80, 0);
        repeat (99) @(posedge clk);
        #1;
        check("to_busy_99", busy, 1);
        @(posedge clk) #1;
        check("to_busy_100", busy, 0);
        check("to_ovr", overrun, 1);
        check("to_no_we", wr_q.size() - tb0, 0);
        ref_ovr = 1'b1;
        run_cmd(8'h07, 16'h0000, 8'h00);
`endif

        check("one_strobe", both_strobes, 0);
        check("tx_stable", unstable, 0);
        check("tx_start_busy", start_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
- Device-side responder for the host debug UART command protocol.
- Parses bytes from the on-chip UART receiver and executes system-bus writes and reads.
- Returns read data through the on-chip UART transmitter.
- Holds or releases the CPU/PPU for memory loading.
- Sits between uart_rx/UART_TX and the system-bus arbiter in the top level.

Parameters:
- RD_LAT, 2, cycles from mem_re pulse to valid mem_rdata (1..15).
- ERR_BYTE, 8'hEE, byte returned for a read issued while the CPU is not held.
- TIMEOUT_CYCLES, 2500000, inter-byte timeout in clk cycles (100 ms at 25 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_start  out  1  one-cycle strobe to UART_TX
- tx_data  out  8  byte to transmit, stable from tx_start until tx_done
- tx_active  in  1  UART_TX busy
- tx_done  in  1  one-cycle strobe, byte sent
- mem_addr  out  16  system-bus address
- mem_wdata  out  8  write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe
- mem_rdata  in  8  read data, valid RD_LAT cycles after mem_re
- cpu_hold  out  1  1 = CPU/PPU held in reset, bus granted to this block
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; set when a byte is dropped; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; state IDLE; cpu_hold=0 (CPU runs).
- Commands (first byte):
  - 8'h02 WRITE: addr_hi, addr_lo, data.
  - 8'h03 READ: addr_hi, addr_lo; one response byte is returned.
  - 8'h06 HOLD: cpu_hold<=1 on the cycle after the byte.
  - 8'h07 RUN: cpu_hold<=0 on the cycle after the byte.
  - Any other value is ignored; state stays IDLE; overrun is not set.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, WR_EXEC, RD_ISSUE, RD_WAIT, TX_SEND, TX_WAIT.
- IDLE: on rx_valid, decode as above. 02/03 -> ADDR_HI with the opcode latched.
- ADDR_HI: on rx_valid, latch mem_addr[15:8] -> ADDR_LO.
- ADDR_LO: on rx_valid, latch mem_addr[7:0]. WRITE -> DATA; READ -> RD_ISSUE.
- DATA: on rx_valid, latch mem_wdata -> WR_EXEC.
- WR_EXEC (1 cycle):
  - cpu_hold=1: mem_we=1.
  - cpu_hold=0: the write is silently dropped.
  - Next state IDLE in both cases.
  - Write latency: mem_we is asserted exactly 1 cycle after the data byte's rx_valid.
- RD_ISSUE (1 cycle):
  - cpu_hold=1: mem_re=1 -> RD_WAIT.
  - cpu_hold=0: tx_data<=ERR_BYTE -> TX_SEND.
- RD_WAIT: count RD_LAT cycles, capture mem_rdata into tx_data -> TX_SEND.
- TX_SEND: if tx_active=0, pulse tx_start -> TX_WAIT; otherwise wait.
- TX_WAIT: on tx_done -> IDLE.
- rx_valid in RD_ISSUE/RD_WAIT/TX_SEND/TX_WAIT/WR_EXEC: byte dropped, overrun<=1. The host always waits for the response, so this indicates a protocol error.
- mem_addr and mem_wdata hold their last values between commands.
- Only one mem strobe is ever high at a time.
- 16-bit address passes through unmodified. There is no auto-increment.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined: a counter reloads on every rx_valid while in ADDR_HI, ADDR_LO or DATA. If TIMEOUT_CYCLES elapse with no byte, the state returns to IDLE, no bus strobe is issued, and overrun<=1.
- Undefined: a partial command waits indefinitely; no counter is synthesized.

Decomposition:
- Package uart_cmd_pkg holds:
  - enum cmd_op_t: CMD_WRITE=8'h02, CMD_READ=8'h03, CMD_HOLD=8'h06, CMD_RUN=8'h07
  - enum cmd_state_t for the states above
  - localparam DEFAULT_ERR_BYTE
- Sub-module rd_lat_counter: a loadable down-counter, reused for RD_LAT and the optional timeout.
- Everything else stays in one always_ff FSM.

Test Plan:
- Write while held: bytes 06, then 02,80,00,A5 -> cpu_hold=1; mem_we pulses once with mem_addr=16'h8000, mem_wdata=8'hA5, 1 cycle after the A5 byte.
- Read while held: memory model returns 8'h3C at 16'h0123 with RD_LAT=2. Send 03,01,23 -> mem_re 1 cycle after the last byte; tx_start 3 cycles later with tx_data=8'h3C; one byte is received on the serial line.
- Access while running: after reset, send 02,00,10,55 then 03,00,10 -> no mem_we or mem_re ever asserted; response byte is 8'hEE.
- Unknown and overrun: send 8'h09, then 03,00,00, then 8'h77 while TX_WAIT -> 09 is ignored without overrun; 77 is dropped; overrun=1; one response byte only.
- Reset mid-command: send 02,80 and assert rst=0 -> asynchronously busy=0, cpu_hold=0, mem_we=0. Then send 06,02,80,01,7E -> mem_we with addr 16'h8001, data 8'h7E.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 02,80, then idle 101 cycles -> state IDLE, overrun=1. A following 07 gives cpu_hold=0.
